// File: rtl/redmule_x_scheduler_pkg.sv
// Shared types for the RedMulE X-operand scheduler: FSM state encoding and latched job geometry.
package redmule_x_scheduler_pkg;

   localparam int unsigned XSCHED_SIZEW = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StPromote,
      StCompute,
      StNext,
      StDone
   } x_sched_state_e;

   typedef struct packed {
      logic [XSCHED_SIZEW-1:0] m_size;
      logic [XSCHED_SIZEW-1:0] k_size;
   } x_sched_cfg_t;

endpackage

// File: rtl/redmule_x_tile_geom.sv
// Combinational tile geometry: tile counts, leftovers, active slots and expected beats for
// the tile addressed by (m_idx_i, k_idx_i).
module redmule_x_tile_geom
   import redmule_x_scheduler_pkg::*;
#(
   parameter int unsigned W     = 12,
   parameter int unsigned H     = 4,
   parameter int unsigned D     = 2,
   parameter int unsigned SIZEW = XSCHED_SIZEW
) (
   input  x_sched_cfg_t                           cfg_i,
   input  logic [SIZEW-1:0]                       m_idx_i,
   input  logic [SIZEW-1:0]                       k_idx_i,
   output logic [SIZEW-1:0]                       tm_o,
   output logic [SIZEW-1:0]                       tk_o,
   output logic [$clog2(W):0]                     rows_lftovr_o,
   output logic [$clog2(H*D):0]                   cols_lftovr_o,
   output logic [$clog2(D):0]                     slots_o,
   output logic [$clog2(D*((W+H-1)/H)):0]         beats_exp_o
);

   localparam int unsigned HD = H * D;
   localparam int unsigned RW = $clog2(W) + 1;
   localparam int unsigned CW = $clog2(HD) + 1;
   localparam int unsigned SW = $clog2(D) + 1;
   localparam int unsigned BW = $clog2(D * ((W + H - 1) / H)) + 1;

   logic [31:0] m32, k32, tm32, tk32, rl32, cl32, sl32, re32, be32;

   // 32-bit intermediates keep ceil() from overflowing near the top of the SIZEW range.
   always_comb begin
      m32  = 32'(cfg_i.m_size);
      k32  = 32'(cfg_i.k_size);
      tm32 = (m32 + W - 1) / W;
      tk32 = (k32 + HD - 1) / HD;
      rl32 = (32'(m_idx_i) == tm32 - 32'd1) ? m32 % W : 32'd0;
      cl32 = (32'(k_idx_i) == tk32 - 32'd1) ? k32 % HD : 32'd0;
      sl32 = (cl32 != 32'd0) ? (cl32 + H - 1) / H : D;
      re32 = (rl32 != 32'd0) ? rl32 : W;
      be32 = sl32 * ((re32 + H - 1) / H);
   end

   assign tm_o          = SIZEW'(tm32);
   assign tk_o          = SIZEW'(tk32);
   assign rows_lftovr_o = RW'(rl32);
   assign cols_lftovr_o = CW'(cl32);
   assign slots_o       = SW'(sl32);
   assign beats_exp_o   = BW'(be32);

endmodule

// File: rtl/redmule_x_scheduler.sv
// X operand buffer scheduler for RedMulE: walks X in W x (H*D) tiles and sequences buffer strobes.
// Define REDMULE_XSCHED_PERF_EN to add saturating load/compute stall counters.
module redmule_x_scheduler
   import redmule_x_scheduler_pkg::*;
#(
   parameter int unsigned ARRAY_WIDTH  = 12,
   parameter int unsigned ARRAY_HEIGHT = 4,
   parameter int unsigned D            = 2,
   parameter int unsigned SIZEW        = XSCHED_SIZEW
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  clear_i,
   input  logic                                  start_i,
   input  logic [SIZEW-1:0]                      m_size_i,
   input  logic [SIZEW-1:0]                      k_size_i,
   input  logic                                  x_valid_i,
   output logic                                  x_ready_o,
   input  logic                                  array_ready_i,
   input  logic                                  buf_full_i,
   input  logic                                  buf_empty_i,
   output logic                                  load_o,
   output logic                                  blck_shift_o,
   output logic                                  h_shift_o,
   output logic                                  d_shift_o,
   output logic [$clog2(ARRAY_WIDTH):0]          rows_lftovr_o,
   output logic [$clog2(ARRAY_HEIGHT*D):0]       cols_lftovr_o,
   output logic [$clog2(D):0]                    slots_o,
   output logic                                  busy_o,
   output logic                                  done_o
`ifdef REDMULE_XSCHED_PERF_EN
   ,
   output logic [31:0]                           stall_load_cnt_o,
   output logic [31:0]                           stall_comp_cnt_o
`endif
);

   localparam int unsigned W  = ARRAY_WIDTH;
   localparam int unsigned H  = ARRAY_HEIGHT;
   localparam int unsigned SW = $clog2(D) + 1;
   localparam int unsigned BW = $clog2(D * ((W + H - 1) / H)) + 1;
   localparam int unsigned HW = (H > 1) ? $clog2(H) : 1;

   x_sched_state_e     state_q, state_d;
   x_sched_cfg_t       cfg_q, cfg_d;
   logic [SIZEW-1:0]   m_idx_q, m_idx_d, k_idx_q, k_idx_d, tm, tk;
   logic [BW-1:0]      beat_q, beat_d, beats_exp;
   logic [HW-1:0]      h_q, h_d;
   logic [SW-1:0]      slice_q, slice_d, slots;
   logic               d_pend_q, d_pend_d;
   logic [$clog2(W):0] rows_g;
   logic [$clog2(H*D):0] cols_g;
   logic               in_tile;

   redmule_x_tile_geom #(
      .W     (W),
      .H     (H),
      .D     (D),
      .SIZEW (SIZEW)
   ) i_geom (
      .cfg_i         (cfg_q),
      .m_idx_i       (m_idx_q),
      .k_idx_i       (k_idx_q),
      .tm_o          (tm),
      .tk_o          (tk),
      .rows_lftovr_o (rows_g),
      .cols_lftovr_o (cols_g),
      .slots_o       (slots),
      .beats_exp_o   (beats_exp)
   );

   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      m_idx_d      = m_idx_q;
      k_idx_d      = k_idx_q;
      beat_d       = beat_q;
      h_d          = h_q;
      slice_d      = slice_q;
      d_pend_d     = d_pend_q;
      x_ready_o    = 1'b0;
      load_o       = 1'b0;
      blck_shift_o = 1'b0;
      h_shift_o    = 1'b0;
      d_shift_o    = 1'b0;
      done_o       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               cfg_d.m_size = XSCHED_SIZEW'(m_size_i);
               cfg_d.k_size = XSCHED_SIZEW'(k_size_i);
               m_idx_d      = '0;
               k_idx_d      = '0;
               beat_d       = '0;
               state_d      = (m_size_i == '0 || k_size_i == '0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            x_ready_o = ~buf_full_i;
            load_o    = x_valid_i & ~buf_full_i;
            if (x_valid_i && !buf_full_i) beat_d = beat_q + 1'b1;
            if (buf_full_i || beat_d == beats_exp) begin
               beat_d  = '0;
               state_d = StPromote;
            end
         end
         StPromote: begin
            blck_shift_o = 1'b1;
            h_d          = '0;
            slice_d      = '0;
            d_pend_d     = 1'b0;
            state_d      = StCompute;
         end
         StCompute: begin
            // The d_shift cycle owns the buffer, so array_ready_i is ignored there.
            if (d_pend_q) begin
               d_shift_o = 1'b1;
               d_pend_d  = 1'b0;
               if (slice_q == slots || buf_empty_i) state_d = StNext;
            end else if (buf_empty_i) begin
               state_d = StNext;
            end else if (array_ready_i) begin
               h_shift_o = 1'b1;
               if (h_q == HW'(H - 1)) begin
                  h_d      = '0;
                  slice_d  = slice_q + 1'b1;
                  d_pend_d = 1'b1;
               end else begin
                  h_d = h_q + 1'b1;
               end
            end
         end
         StNext: begin
            h_d     = '0;
            slice_d = '0;
            state_d = StLoad;
            if (k_idx_q == tk - SIZEW'(1)) begin
               k_idx_d = '0;
               if (m_idx_q == tm - SIZEW'(1)) begin
                  m_idx_d = '0;
                  state_d = StDone;
               end else begin
                  m_idx_d = m_idx_q + 1'b1;
               end
            end else begin
               k_idx_d = k_idx_q + 1'b1;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (clear_i) begin
         state_d      = StIdle;
         cfg_d        = '0;
         m_idx_d      = '0;
         k_idx_d      = '0;
         beat_d       = '0;
         h_d          = '0;
         slice_d      = '0;
         d_pend_d     = 1'b0;
         x_ready_o    = 1'b0;
         load_o       = 1'b0;
         blck_shift_o = 1'b0;
         h_shift_o    = 1'b0;
         d_shift_o    = 1'b0;
         done_o       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cfg_q    <= '0;
         m_idx_q  <= '0;
         k_idx_q  <= '0;
         beat_q   <= '0;
         h_q      <= '0;
         slice_q  <= '0;
         d_pend_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cfg_q    <= cfg_d;
         m_idx_q  <= m_idx_d;
         k_idx_q  <= k_idx_d;
         beat_q   <= beat_d;
         h_q      <= h_d;
         slice_q  <= slice_d;
         d_pend_q <= d_pend_d;
      end
   end

   // Geometry is only meaningful while a tile is in flight; IDLE and DONE present zeros.
   assign in_tile       = (state_q != StIdle) && (state_q != StDone);
   assign rows_lftovr_o = in_tile ? rows_g : '0;
   assign cols_lftovr_o = in_tile ? cols_g : '0;
   assign slots_o       = in_tile ? slots  : '0;
   assign busy_o        = (state_q != StIdle);

`ifdef REDMULE_XSCHED_PERF_EN
   logic [31:0] stall_load_q, stall_comp_q;
   logic        perf_clr;

   assign perf_clr = clear_i || ((state_q == StIdle) && start_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_load_q <= '0;
         stall_comp_q <= '0;
      end else if (perf_clr) begin
         stall_load_q <= '0;
         stall_comp_q <= '0;
      end else begin
         if (state_q == StLoad && !x_valid_i && stall_load_q != '1) begin
            stall_load_q <= stall_load_q + 32'd1;
         end
         if (state_q == StCompute && !array_ready_i && stall_comp_q != '1) begin
            stall_comp_q <= stall_comp_q + 32'd1;
         end
      end
   end

   assign stall_load_cnt_o = stall_load_q;
   assign stall_comp_cnt_o = stall_comp_q;
`endif

endmodule

// File: tb/tb_redmule_x_scheduler.sv
// Self-checking bench for redmule_x_scheduler: jobs with random stream/array gaps are scored
// against a tile-level model of strobe totals and per-tile geometry.
module tb_redmule_x_scheduler;

   localparam int unsigned W  = 12;
   localparam int unsigned H  = 4;
   localparam int unsigned D  = 2;
   localparam int unsigned HD = H * D;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear_i = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] m_size_i = '0;
   logic [15:0] k_size_i = '0;
   logic        x_valid_i = 1'b0;
   logic        array_ready_i = 1'b0;
   logic        buf_full_i = 1'b0;
   logic        buf_empty_i = 1'b0;
   logic        x_ready_o, load_o, blck_shift_o, h_shift_o, d_shift_o, busy_o, done_o;
   logic [4:0]  rows_lftovr_o;
   logic [3:0]  cols_lftovr_o;
   logic [1:0]  slots_o;
`ifdef REDMULE_XSCHED_PERF_EN
   logic [31:0] stall_load_cnt_o, stall_comp_cnt_o;
`endif

   redmule_x_scheduler #(
      .ARRAY_WIDTH  (W),
      .ARRAY_HEIGHT (H),
      .D            (D),
      .SIZEW        (16)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .start_i       (start_i),
      .m_size_i      (m_size_i),
      .k_size_i      (k_size_i),
      .x_valid_i     (x_valid_i),
      .x_ready_o     (x_ready_o),
      .array_ready_i (array_ready_i),
      .buf_full_i    (buf_full_i),
      .buf_empty_i   (buf_empty_i),
      .load_o        (load_o),
      .blck_shift_o  (blck_shift_o),
      .h_shift_o     (h_shift_o),
      .d_shift_o     (d_shift_o),
      .rows_lftovr_o (rows_lftovr_o),
      .cols_lftovr_o (cols_lftovr_o),
      .slots_o       (slots_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
`ifdef REDMULE_XSCHED_PERF_EN
      ,
      .stall_load_cnt_o (stall_load_cnt_o),
      .stall_comp_cnt_o (stall_comp_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   int exp_load, exp_blck, exp_h, exp_d;
   int exp_rows[$], exp_cols[$], exp_slots[$];

   int obs_load, obs_blck, obs_h, obs_d, obs_done, obs_excl, obs_lat, obs_first_ready;
   int obs_timeout, gap_load, gap_comp;
   int obs_rows[$], obs_cols[$], obs_slots[$];

   // Tile-level reference: walk tiles k-inner, m-outer and total what each tile must emit.
   task automatic model_job(input int m, input int k);
      int tm, tk, rows, cols, slots, reff;
      exp_load = 0; exp_blck = 0; exp_h = 0; exp_d = 0;
      exp_rows.delete(); exp_cols.delete(); exp_slots.delete();
      tm = (m + W - 1) / W;
      tk = (k + HD - 1) / HD;
      if (m == 0 || k == 0) begin tm = 0; tk = 0; end
      for (int mi = 0; mi < tm; mi++) begin
         for (int ki = 0; ki < tk; ki++) begin
            rows  = (mi == tm - 1) ? m % W : 0;
            cols  = (ki == tk - 1) ? k % HD : 0;
            slots = (cols != 0) ? (cols + H - 1) / H : D;
            reff  = (rows != 0) ? rows : W;
            exp_load += slots * ((reff + H - 1) / H);
            exp_blck += 1;
            exp_h    += slots * H;
            exp_d    += slots;
            exp_rows.push_back(rows);
            exp_cols.push_back(cols);
            exp_slots.push_back(slots);
         end
      end
   endtask

   // Starts a job from IDLE and observes it to done_o; gap is the percent chance of a stall.
   task automatic run_job(input int m, input int k, input int gap);
      int  last_load, tile_d, cur_slots, nstrb;
      bit  done_seen, in_comp;
      obs_load = 0; obs_blck = 0; obs_h = 0; obs_d = 0; obs_done = 0; obs_excl = 0;
      obs_lat = 0; obs_first_ready = 0; obs_timeout = 0; gap_load = 0; gap_comp = 0;
      obs_rows.delete(); obs_cols.delete(); obs_slots.delete();
      last_load = -10; tile_d = 0; cur_slots = 0; done_seen = 0; in_comp = 0;
      m_size_i = 16'(m); k_size_i = 16'(k);
      start_i = 1'b1; x_valid_i = 1'b1; array_ready_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         x_valid_i     = (gap == 0) || ($urandom_range(99) >= gap);
         array_ready_i = (gap == 0) || ($urandom_range(99) >= gap);
         #2;
         if (c == 0) obs_first_ready = int'(x_ready_o);
         nstrb = int'(load_o) + int'(blck_shift_o) + int'(h_shift_o) + int'(d_shift_o);
         if (nstrb > 1) obs_excl++;
         if (x_ready_o && !x_valid_i) gap_load++;
         if (load_o) begin obs_load++; last_load = c; end
         if (blck_shift_o) begin
            obs_blck++;
            if (last_load != c - 1) obs_lat++;
            obs_rows.push_back(int'(rows_lftovr_o));
            obs_cols.push_back(int'(cols_lftovr_o));
            obs_slots.push_back(int'(slots_o));
            cur_slots = int'(slots_o); tile_d = 0; in_comp = 1;
         end else if (in_comp) begin
            if (!array_ready_i) gap_comp++;
            if (d_shift_o) begin
               tile_d++;
               if (tile_d == cur_slots) in_comp = 0;
            end
         end
         if (h_shift_o) obs_h++;
         if (d_shift_o) obs_d++;
         if (done_o) begin obs_done++; done_seen = 1; end
         @(posedge clk_i); #1;
         if (done_seen) break;
      end
      if (!done_seen) obs_timeout = 1;
      x_valid_i = 1'b0; array_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++;
      if ({load_o, blck_shift_o, h_shift_o, d_shift_o, x_ready_o, busy_o, done_o} !== 7'b0)
         $display("FAIL reset_strobes: got %b want 0",
                  {load_o, blck_shift_o, h_shift_o, d_shift_o, x_ready_o, busy_o, done_o});
      else n_pass++;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      n_checks++;
      if ({rows_lftovr_o, cols_lftovr_o, slots_o, busy_o} !== 12'b0)
         $display("FAIL idle_outputs: got %h want 0",
                  {rows_lftovr_o, cols_lftovr_o, slots_o, busy_o});
      else n_pass++;
   endtask

   task automatic test_geometry();
      int tab_m[6];
      int tab_k[6];
      tab_m = '{12, 14, 12, 1, 0, 37};
      tab_k = '{8, 8, 10, 1, 5, 21};
      for (int t = 0; t < 6; t++) begin
         model_job(tab_m[t], tab_k[t]);
         run_job(tab_m[t], tab_k[t], 0);
         n_checks++;
         if (obs_timeout != 0 || obs_done != 1)
            $display("FAIL geom_done[%0d]: got done=%0d timeout=%0d want done=1", t, obs_done,
                     obs_timeout);
         else n_pass++;
         n_checks++;
         if (obs_load != exp_load) $display("FAIL geom_loads[%0d]: got %0d want %0d", t, obs_load,
                                            exp_load);
         else n_pass++;
         n_checks++;
         if (obs_blck != exp_blck) $display("FAIL geom_blck[%0d]: got %0d want %0d", t, obs_blck,
                                            exp_blck);
         else n_pass++;
         n_checks++;
         if (obs_h != exp_h) $display("FAIL geom_h[%0d]: got %0d want %0d", t, obs_h, exp_h);
         else n_pass++;
         n_checks++;
         if (obs_d != exp_d) $display("FAIL geom_d[%0d]: got %0d want %0d", t, obs_d, exp_d);
         else n_pass++;
         n_checks++;
         if (obs_excl != 0 || obs_lat != 0)
            $display("FAIL geom_excl_lat[%0d]: got excl=%0d lat=%0d want 0/0", t, obs_excl,
                     obs_lat);
         else n_pass++;
         if (exp_blck > 0) begin
            n_checks++;
            if (obs_first_ready != 1)
               $display("FAIL geom_first_ready[%0d]: got %0d want 1", t, obs_first_ready);
            else n_pass++;
         end
         n_checks++;
         if (obs_rows.size() != exp_rows.size())
            $display("FAIL geom_tiles[%0d]: got %0d want %0d", t, obs_rows.size(),
                     exp_rows.size());
         else n_pass++;
         for (int i = 0; i < obs_rows.size() && i < exp_rows.size(); i++) begin
            n_checks++;
            if (obs_rows[i] != exp_rows[i] || obs_cols[i] != exp_cols[i] ||
                obs_slots[i] != exp_slots[i])
               $display("FAIL geom_lftovr[%0d.%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", t, i,
                        obs_rows[i], obs_cols[i], obs_slots[i], exp_rows[i], exp_cols[i],
                        exp_slots[i]);
            else n_pass++;
         end
         #2;
         n_checks++;
         if (busy_o !== 1'b0) $display("FAIL geom_busy_after[%0d]: got %b want 0", t, busy_o);
         else n_pass++;
      end
   endtask

   task automatic test_random_gaps();
      int ms[3];
      int ks[3];
      ms = '{24, 24, 1 + int'($urandom_range(39))};
      ks = '{16, 16, 1 + int'($urandom_range(29))};
      for (int t = 0; t < 3; t++) begin
         model_job(ms[t], ks[t]);
         run_job(ms[t], ks[t], 30);
         n_checks++;
         if (obs_timeout != 0 || obs_done != 1)
            $display("FAIL gap_done[%0d]: got done=%0d timeout=%0d want 1/0", t, obs_done,
                     obs_timeout);
         else n_pass++;
         n_checks++;
         if (obs_load != exp_load || obs_blck != exp_blck || obs_h != exp_h || obs_d != exp_d)
            $display("FAIL gap_totals[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", t,
                     obs_load, obs_blck, obs_h, obs_d, exp_load, exp_blck, exp_h, exp_d);
         else n_pass++;
         n_checks++;
         if (obs_excl != 0 || obs_lat != 0)
            $display("FAIL gap_excl_lat[%0d]: got excl=%0d lat=%0d want 0/0", t, obs_excl,
                     obs_lat);
         else n_pass++;
`ifdef REDMULE_XSCHED_PERF_EN
         n_checks++;
         if (stall_load_cnt_o !== 32'(gap_load))
            $display("FAIL perf_load[%0d]: got %0d want %0d", t, stall_load_cnt_o, gap_load);
         else n_pass++;
         n_checks++;
         if (stall_comp_cnt_o !== 32'(gap_comp))
            $display("FAIL perf_comp[%0d]: got %0d want %0d", t, stall_comp_cnt_o, gap_comp);
         else n_pass++;
`endif
      end
   endtask

   task automatic test_buf_full();
      int  h_cnt, d_cnt;
      bit  done_seen;
      h_cnt = 0; d_cnt = 0; done_seen = 0;
      m_size_i = 16'd12; k_size_i = 16'd8;
      start_i = 1'b1; x_valid_i = 1'b1; array_ready_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++;
         if (load_o !== 1'b1) $display("FAIL full_load[%0d]: got %b want 1", i, load_o);
         else n_pass++;
         @(posedge clk_i); #1;
      end
      buf_full_i = 1'b1;
      #2;
      n_checks++;
      if ({x_ready_o, load_o} !== 2'b00)
         $display("FAIL full_ready_drop: got %b want 00", {x_ready_o, load_o});
      else n_pass++;
      @(posedge clk_i); #1;
      #2;
      n_checks++;
      if (blck_shift_o !== 1'b1) $display("FAIL full_promote: got %b want 1", blck_shift_o);
      else n_pass++;
      buf_full_i = 1'b0;
      @(posedge clk_i); #1;
      for (int c = 0; c < 100; c++) begin
         #2;
         if (h_shift_o) h_cnt++;
         if (d_shift_o) d_cnt++;
         if (done_o) done_seen = 1;
         @(posedge clk_i); #1;
         if (done_seen) break;
      end
      n_checks++;
      if (!done_seen || h_cnt != 8 || d_cnt != 2)
         $display("FAIL full_compute: got done=%0d h=%0d d=%0d want 1/8/2", done_seen, h_cnt,
                  d_cnt);
      else n_pass++;
      x_valid_i = 1'b0; array_ready_i = 1'b0;
   endtask

   task automatic test_clear();
      bit seen;
      int done_cnt;
      seen = 0; done_cnt = 0;
      m_size_i = 16'd24; k_size_i = 16'd16;
      start_i = 1'b1; x_valid_i = 1'b1; array_ready_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         #2;
         if (h_shift_o) seen = 1;
         else begin @(posedge clk_i); #1; end
      end
      n_checks++;
      if (!seen) $display("FAIL clear_reach_compute: got 0 want 1");
      else n_pass++;
      clear_i = 1'b1;
      @(posedge clk_i); #1;
      clear_i = 1'b0;
      #2;
      n_checks++;
      if ({load_o, blck_shift_o, h_shift_o, d_shift_o, x_ready_o, busy_o, done_o,
           rows_lftovr_o, cols_lftovr_o, slots_o} !== 18'b0)
         $display("FAIL clear_outputs: got %h want 0", {load_o, blck_shift_o, h_shift_o,
                  d_shift_o, x_ready_o, busy_o, done_o, rows_lftovr_o, cols_lftovr_o, slots_o});
      else n_pass++;
`ifdef REDMULE_XSCHED_PERF_EN
      n_checks++;
      if ({stall_load_cnt_o, stall_comp_cnt_o} !== 64'b0)
         $display("FAIL clear_perf: got %0d/%0d want 0/0", stall_load_cnt_o, stall_comp_cnt_o);
      else n_pass++;
`endif
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_i); #3;
         if (done_o) done_cnt++;
      end
      n_checks++;
      if (done_cnt != 0) $display("FAIL clear_no_done: got %0d want 0", done_cnt);
      else n_pass++;
      @(posedge clk_i); #1;
      model_job(12, 10);
      run_job(12, 10, 0);
      n_checks++;
      if (obs_done != 1 || obs_load != exp_load || obs_h != exp_h || obs_d != exp_d)
         $display("FAIL clear_rerun: got %0d/%0d/%0d/%0d want 1/%0d/%0d/%0d", obs_done,
                  obs_load, obs_h, obs_d, exp_load, exp_h, exp_d);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      m_size_i = 16'd24; k_size_i = 16'd16;
      start_i = 1'b1; x_valid_i = 1'b1; array_ready_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #2;
      n_checks++;
      if ({load_o, x_ready_o, busy_o, done_o} !== 4'b0)
         $display("FAIL rst_async: got %b want 0", {load_o, x_ready_o, busy_o, done_o});
      else n_pass++;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      #2;
      n_checks++;
      if ({load_o, blck_shift_o, h_shift_o, d_shift_o, x_ready_o, busy_o, done_o,
           rows_lftovr_o, cols_lftovr_o, slots_o} !== 18'b0)
         $display("FAIL rst_outputs: got %h want 0", {load_o, blck_shift_o, h_shift_o,
                  d_shift_o, x_ready_o, busy_o, done_o, rows_lftovr_o, cols_lftovr_o, slots_o});
      else n_pass++;
      @(posedge clk_i); #1;
      model_job(14, 8);
      run_job(14, 8, 0);
      n_checks++;
      if (obs_done != 1 || obs_load != exp_load || obs_blck != exp_blck || obs_h != exp_h)
         $display("FAIL rst_rerun: got %0d/%0d/%0d/%0d want 1/%0d/%0d/%0d", obs_done, obs_load,
                  obs_blck, obs_h, exp_load, exp_blck, exp_h);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_geometry();
      test_random_gaps();
      test_buf_full();
      test_clear();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/redmule_x_scheduler.md
Name: redmule_x_scheduler

Overview:
- Sequences the X operand buffer of the RedMulE engine.
- Walks an M×K X matrix in tiles of W rows × (H·D) columns.
- Per tile: accepts streamer beats into the buffer (load), promotes one slice into the output stage (blck_shift), then paces the array with h_shift/d_shift as the array consumes.
- Sits between the X streamer, the x buffer and the top-level RedMulE controller.

Parameters:
- W, ARRAY_WIDTH (12): array rows / buffer width.
- H, ARRAY_HEIGHT (4): PEs per row; h_shift steps per depth slice.
- D, 2: buffer depth slices per tile.
- SIZEW, 16: width of the M and K size fields.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active-low
- clear_i  in  1  sync soft clear
- start_i  in  1  one-cycle job start; samples cfg
- m_size_i  in  SIZEW  X rows (M ≥ 1)
- k_size_i  in  SIZEW  X cols (K ≥ 1)
- x_valid_i  in  1  streamer beat valid
- x_ready_o  out  1  beat accepted when valid&ready
- array_ready_i  in  1  array consumes one H-column step this cycle
- buf_full_i  in  1  x buffer flags.full
- buf_empty_i  in  1  x buffer flags.empty
- load_o, blck_shift_o, h_shift_o, d_shift_o  out  1 each  buffer ctrl strobes
- rows_lftovr_o  out  $clog2(W)+1  M mod W on last row-tile, else 0
- cols_lftovr_o  out  $clog2(H*D)+1  K mod (H·D) on last col-tile, else 0
- slots_o  out  $clog2(D)+1  ceil(cols_lftovr/H), else D
- busy_o  out  1  high from start through DONE
- done_o  out  1  one-cycle pulse at job end

Behaviour:
- Reset / clear_i: state IDLE; all counters 0; all outputs 0.
- clear_i has priority over every other input.
- Tile counts latched at start: TM = ceil(M/W), TK = ceil(K/(H·D)).
- Tile order: k-tile inner, m-tile outer.
- Current tile geometry:
  - rows_eff = rows_lftovr if nonzero, else W.
  - slots_eff = slots_o.
  - beats_exp = slots_eff·ceil(rows_eff/H).
- IDLE: start_i → LOAD, busy_o=1. start_i outside IDLE is ignored.
- LOAD:
  - x_ready_o = ~buf_full_i.
  - load_o = x_valid_i & x_ready_o; beat counter increments on each load.
  - When buf_full_i, or beat counter == beats_exp, next cycle → PROMOTE; beat counter cleared.
- PROMOTE: blck_shift_o=1 for exactly one cycle → COMPUTE.
- COMPUTE:
  - h_shift_o = array_ready_i; h counter 0..H-1.
  - On the H-th step: h counter wraps, d_shift_o pulses the following cycle, and the slice counter increments.
  - When slice counter == slots_eff, or buf_empty_i → NEXT.
  - h_shift and d_shift are never asserted in the same cycle; array_ready_i is ignored during the d_shift cycle.
- NEXT:
  - Advance the k-tile index; on wrap, advance the m-tile index.
  - If both indices wrap → DONE, else → LOAD.
  - Leftover outputs are recomputed combinationally from the indices and are stable throughout a tile.
- DONE: done_o=1 for one cycle; busy_o=0 next cycle → IDLE.
- M or K = 0 at start: go directly to DONE; no strobes.
- load_o, blck_shift_o, h_shift_o and d_shift_o are mutually exclusive in every cycle.
- Latencies: start→first x_ready_o 1 cycle; last accepted beat→blck_shift_o 1 cycle.

Optional Feature:
- Macro: REDMULE_XSCHED_PERF_EN.
- With the macro: adds outputs stall_load_cnt_o [31:0] and stall_comp_cnt_o [31:0], both saturating.
  - stall_load_cnt_o counts LOAD cycles with ~x_valid_i.
  - stall_comp_cnt_o counts COMPUTE cycles with ~array_ready_i.
  - Both cleared on start_i and on clear_i.
- Without the macro: ports and logic absent; behaviour otherwise identical.

Decomposition:
- redmule_pkg: state enum x_sched_state_e (IDLE, LOAD, PROMOTE, COMPUTE, NEXT, DONE); struct x_sched_cfg_t {m_size, k_size}. The existing x_buffer_ctrl_t/x_buffer_flgs_t are reused by the wrapper that packs the strobes.
- One sub-module: redmule_x_tile_geom, combinational; computes TM, TK, rows_lftovr, cols_lftovr, slots and beats_exp from cfg and tile indices.

Test Plan (W=12, H=4, D=2):
- M=12, K=8, x_valid_i and array_ready_i held high:
  - Required: 6 loads, 1 blck_shift, 8 h_shifts and 2 d_shifts, then one done_o pulse.
  - Required: rows_lftovr=0, cols_lftovr=0, slots=2.
- M=14, K=8:
  - Required: TM=2.
  - Required: second tile rows_lftovr=2, beats_exp=2, exactly 2 loads, then done_o.
- M=12, K=10:
  - Required: TK=2.
  - Required: second tile cols_lftovr=2, slots=1, 1 d_shift, 4 h_shifts.
- Random ~x_valid_i / ~array_ready_i gaps, M=24, K=16:
  - Required: strobe totals match the gap-free run.
  - Required: no two strobes in one cycle; with REDMULE_XSCHED_PERF_EN, counters equal the injected gap cycles.
- buf_full_i forced early after 3 beats:
  - Required: x_ready_o drops the same cycle; PROMOTE follows.
- clear_i mid-COMPUTE, and rst_ni low mid-LOAD:
  - Required: next cycle IDLE, all outputs 0, no done_o.
  - Required: a new start_i runs the job correctly.
